// File: rtl/rf_write_bank.sv
// Write side and storage of the general-purpose register file: one-hot write decode,
// register array, two combinational read ports with optional bypass, dirty mask and write counter.
module rf_write_bank #(
    parameter int REGISTER_SIZE = 15,
    parameter int BINARY_SELECT = 2,
    parameter bit BYPASS        = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  write_en,
    input  logic [BINARY_SELECT:0]                write_reg,
    input  logic [REGISTER_SIZE:0]                write_data,
    input  logic [BINARY_SELECT:0]                read1_reg,
    input  logic [BINARY_SELECT:0]                read2_reg,
    output logic [REGISTER_SIZE:0]                read1_data,
    output logic [REGISTER_SIZE:0]                read2_data,
    input  logic                                  dirty_clr,
    output logic [(1 << (BINARY_SELECT + 1))-1:0] dirty_mask,
    output logic [15:0]                           write_count,
    output logic                                  err
);

    localparam int NREG = 1 << (BINARY_SELECT + 1);
    localparam int DW   = REGISTER_SIZE + 1;

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] strobe_s;
    logic [NREG-1:0] dirty_q;
    logic [NREG-1:0] dirty_d;
    logic [15:0]     count_q;
    logic [15:0]     count_d;
    logic            err_q;
    logic            err_d;

    // X/Z detection only exists in simulation; the synthesized netlist never flags.
    function automatic logic write_has_unknown(input logic [BINARY_SELECT:0] sel,
                                               input logic [DW-1:0]          data);
`ifdef SYNTHESIS
        write_has_unknown = 1'b0;
`else
        write_has_unknown = $isunknown(sel) || $isunknown(data);
`endif
    endfunction

    // One-hot write strobes, all low when no write is requested.
    always_comb begin
        strobe_s = {NREG{1'b0}};
        if (write_en) begin
            strobe_s[write_reg] = 1'b1;
        end else begin
            strobe_s = {NREG{1'b0}};
        end
    end

    // Next-state for mask, counter and sticky error; clear wins before the new set.
    always_comb begin
        dirty_d = dirty_q;
        count_d = count_q;
        err_d   = err_q;
        if (dirty_clr) begin
            dirty_d = strobe_s;
        end else begin
            dirty_d = dirty_q | strobe_s;
        end
        if (write_en) begin
            count_d = count_q + 16'd1;
            err_d   = err_q | write_has_unknown(write_reg, write_data);
        end else begin
            count_d = count_q;
            err_d   = err_q;
        end
    end

    // Register array and status state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
            dirty_q <= {NREG{1'b0}};
            count_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (strobe_s[i]) begin
                    regs_q[i] <= write_data;
                end
            end
            dirty_q <= dirty_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Read ports; each port bypasses independently on a same-cycle write hit.
    always_comb begin
        read1_data = regs_q[read1_reg];
        read2_data = regs_q[read2_reg];
        if (BYPASS && write_en && (write_reg == read1_reg)) begin
            read1_data = write_data;
        end else begin
            read1_data = regs_q[read1_reg];
        end
        if (BYPASS && write_en && (write_reg == read2_reg)) begin
            read2_data = write_data;
        end else begin
            read2_data = regs_q[read2_reg];
        end
    end

    assign dirty_mask  = dirty_q;
    assign write_count = count_q;
    assign err         = err_q;

endmodule
